demux4_stream_v1: RTL and testbench

- Registered 1-to-4 stream demultiplexer with valid/ready handshakes on every side.
- Accepts one {sel, data} beat per cycle and delivers it in order to the output channel named by sel.
- Used wherever one producer, such as the issue/dispatch path, fans out to up to four consumers, such as functional units or writeback ports.
- Holds beats in a 2-entry in-order buffer so a stalled consumer never corrupts data or drops beats.

---
 rtl/demux4_stream_v1.sv | 113 +++++++++++
 tb/tb_demux4_stream_v1.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_stream_v1.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a 2-entry in-order buffer.
// Optional per-channel delivered-beat counters are built when DEMUX_PERF_CNT_EN is defined.
module demux4_stream_v1 #(
   parameter int unsigned width     = 32,
   parameter int unsigned cnt_width = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_sel,
   input  logic [width-1:0]       in_data,
   output logic [3:0]             out_valid,
   input  logic [3:0]             out_ready,
   output logic [width-1:0]       out_data,
   input  logic                   cnt_clr,
   output logic [4*cnt_width-1:0] cnt_out
);

   logic [1:0]       sel_q  [2];
   logic [width-1:0] data_q [2];
   logic [1:0]       count_q;
   logic             rd_ptr_q;
   logic             wr_ptr_q;

   logic             push;
   logic             pop;
   logic [1:0]       count_nxt;
   logic             rd_nxt;
   logic [1:0]       head_sel_nxt;
   logic [width-1:0] head_data_nxt;
   logic [3:0]       valid_nxt;

   // Next occupancy and next head; outputs are registered from these so no input reaches an output combinationally.
   always_comb begin
      push          = in_valid & in_ready;
      pop           = |(out_valid & out_ready);
      count_nxt     = count_q;
      rd_nxt        = rd_ptr_q ^ pop;
      head_sel_nxt  = 2'd0;
      head_data_nxt = '0;
      valid_nxt     = 4'b0000;
      if (push && !pop) begin
         count_nxt = count_q + 2'(1);
      end else if (pop && !push) begin
         count_nxt = count_q - 2'(1);
      end
      if (count_nxt != 2'd0) begin
         // The new head is the beat being written when the read pointer lands on the write slot.
         if (push && (rd_nxt == wr_ptr_q)) begin
            head_sel_nxt  = in_sel;
            head_data_nxt = in_data;
         end else begin
            head_sel_nxt  = sel_q[rd_nxt];
            head_data_nxt = data_q[rd_nxt];
         end
         valid_nxt = 4'(1) << head_sel_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= 2'd0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 4'b0000;
         out_data  <= '0;
         for (int i = 0; i < 2; i++) begin
            sel_q[i]  <= 2'd0;
            data_q[i] <= '0;
         end
      end else begin
         count_q   <= count_nxt;
         rd_ptr_q  <= rd_nxt;
         wr_ptr_q  <= wr_ptr_q ^ push;
         in_ready  <= (count_nxt != 2'd2);
         out_valid <= valid_nxt;
         out_data  <= head_data_nxt;
         if (push) begin
            sel_q[wr_ptr_q]  <= in_sel;
            data_q[wr_ptr_q] <= in_data;
         end
      end
   end

`ifdef DEMUX_PERF_CNT_EN
   logic [3:0][cnt_width-1:0] cnt_q;

   // Saturating per-channel pop counters; a clear beats a coincident pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (cnt_clr) begin
               cnt_q[k] <= '0;
            end else if (out_valid[k] && out_ready[k] && (cnt_q[k] != {cnt_width{1'b1}})) begin
               cnt_q[k] <= cnt_q[k] + cnt_width'(1);
            end
         end
      end
   end

   assign cnt_out = cnt_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_demux4_stream_v1.sv
// Directed and scoreboarded bench for demux4_stream_v1 (default parameters).
module tb_demux4_stream_v1;

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_sel;
   logic [W-1:0]  in_data;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [W-1:0]  out_data;
   logic          cnt_clr;
   logic [4*CW-1:0] cnt_out;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] data;
   } beat_t;

   beat_t q[$];

   demux4_stream_v1 #(.width(W), .cnt_width(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cnt_clr   (cnt_clr),
      .cnt_out   (cnt_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int sent;
      int cycles;
      bit push_m;
      bit pop_m;
      logic [3:0] exp_v;
      logic [W-1:0] exp_d;

      // reset held with a pending producer beat
      rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hDEAD_BEEF;
      out_ready = 4'b1111; cnt_clr = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 4'b0000);
      check("rst_out_data", out_data, 0);
      check("rst_cnt", cnt_out, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick(); tick();
      check("post_rst_valid", out_valid, 4'b0000);

      // back-to-back streaming with all consumers ready
      in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hA5A5_0001;
      tick();
      check("stream1_valid", out_valid, 4'b0100);
      check("stream1_data", out_data, 32'hA5A5_0001);
      check("stream1_ready", in_ready, 1);
      in_sel = 2'd0; in_data = 32'h0000_0002;
      tick();
      check("stream2_valid", out_valid, 4'b0001);
      check("stream2_data", out_data, 32'h0000_0002);
      check("stream2_ready", in_ready, 1);
      in_valid = 1'b0;
      tick();
      check("stream_empty", out_valid, 4'b0000);
      check("stream_empty_data", out_data, 0);

      // stall and head-of-line blocking
      out_ready = 4'b0000;
      in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11;
      tick();
      check("stall1_valid", out_valid, 4'b0010);
      check("stall1_ready", in_ready, 1);
      in_sel = 2'd3; in_data = 32'h33;
      tick();
      check("stall2_ready", in_ready, 0);
      check("stall2_valid", out_valid, 4'b0010);
      in_sel = 2'd0; in_data = 32'h99;
      tick();
      check("stall3_ready", in_ready, 0);
      check("stall3_valid", out_valid, 4'b0010);
      check("stall3_data", out_data, 32'h11);
      in_valid = 1'b0;
      out_ready = 4'b1000;
      tick();
      check("hol_valid", out_valid, 4'b0010);
      check("hol_data", out_data, 32'h11);
      out_ready = 4'b0010;
      tick();
      check("hol_pop_valid", out_valid, 4'b1000);
      check("hol_pop_data", out_data, 32'h33);
      check("hol_pop_ready", in_ready, 1);
      out_ready = 4'b1000;
      tick();
      check("hol_drain_valid", out_valid, 4'b0000);
      check("hol_drain_ready", in_ready, 1);

      // simultaneous push/pop at count 1: in_ready stays high
      out_ready = 4'b1111;
      in_valid = 1'b1; in_sel = 2'd3; in_data = 32'h100;
      tick();
      for (int i = 1; i <= 3; i++) begin
         in_sel = 2'(i); in_data = 32'h100 + W'(i);
         tick();
         check("pushpop_ready", in_ready, 1);
         check("pushpop_valid", out_valid, 4'(1) << 2'(i));
         check("pushpop_data", out_data, 32'h100 + W'(i));
      end
      in_valid = 1'b0;
      tick();
      check("pushpop_empty", out_valid, 4'b0000);

      // 100 random beats against a queue model
      sent = 0; cycles = 0;
      q.delete();
      while ((sent < 100 || q.size() != 0) && cycles < 3000) begin
         exp_v = (q.size() != 0) ? (4'(1) << q[0].sel) : 4'b0000;
         exp_d = (q.size() != 0) ? q[0].data : '0;
         check("rnd_ready", in_ready, (q.size() < 2) ? 1 : 0);
         check("rnd_valid", out_valid, exp_v);
         check("rnd_data", out_data, exp_d);
         in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = $urandom;
         out_ready = 4'($urandom_range(0, 15));
         push_m = in_valid && (q.size() < 2);
         pop_m  = (q.size() != 0) && out_ready[q[0].sel];
         if (pop_m) void'(q.pop_front());
         if (push_m) begin
            q.push_back('{sel: in_sel, data: in_data});
            sent++;
         end
         tick();
         cycles++;
      end
      check("rnd_completed", (cycles < 3000) ? 1 : 0, 1);
      in_valid = 1'b0;

      // asynchronous reset between edges with two beats buffered
      out_ready = 4'b0000;
      in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h77;
      tick();
      in_sel = 2'd3; in_data = 32'h88;
      tick();
      in_valid = 1'b0;
      check("arst_pre_ready", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 4'b0000);
      check("arst_data", out_data, 0);
      check("arst_ready", in_ready, 1);
      #1 rst_n = 1'b1;
      out_ready = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("arst_after_valid", out_valid, 4'b0000);
      end
      in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h42;
      tick();
      in_valid = 1'b0;
      check("arst_new_valid", out_valid, 4'b0001);
      check("arst_new_data", out_data, 32'h42);
      tick();

      // beat counters
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      out_ready = 4'b1111;
      in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h5;
      repeat (3) tick();
      in_valid = 1'b0;
      tick(); tick();
`ifdef DEMUX_PERF_CNT_EN
      check("cnt2_three", cnt_out[2*CW +: CW], 3);
      check("cnt0_zero", cnt_out[0 +: CW], 0);
`else
      check("cnt_tied0_a", cnt_out, 0);
`endif
      out_ready = 4'b0000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      out_ready = 4'b1111; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_pop_valid", out_valid, 4'b0000);
      check("clr_pop_cnt", cnt_out, 0);
`ifdef DEMUX_PERF_CNT_EN
      force dut.cnt_q = {16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
      #1 release dut.cnt_q;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      check("cnt_sat", cnt_out[2*CW +: CW], 16'hFFFF);
`else
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      check("cnt_tied0_b", cnt_out, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
